execuation_stage_md: RTL and testbench
======================================

Name: execuation_stage_md

Overview:
- Pipeline execute stage. Sits between decode and the memory stage and produces `pipeline_result_execuation_t` for the memory stage.
- Resolves operand hazards through two ForwardingUnit instances.
- Computes the single-cycle ALU result and the data memory address.
- Owns the HI/LO registers and an iterative multiply/divide (MD) unit. The MD unit runs in the background and stalls decode only when a dependent MD instruction arrives.

Parameters:
- MD_BITS_PER_CYCLE, 1, quotient/product bits resolved per MD iteration. Legal values 1, 2, 4. MD latency N = 32/MD_BITS_PER_CYCLE cycles.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- pipelineResultDecode  in  pipeline_result_decode_t  decode output; includes bubbled, signals, regReadId, regData, immediate
- resultOfInstructionAfterMemory  in  stage_register_data_t  forwarding source, memory stage
- resultOfInstructionAfterWriteback  in  stage_register_data_t  forwarding source, writeback stage
- flush  in  1  kill the instruction currently presented by decode
- stallRequest  out  1  decode must hold its output this cycle
- pipelineResultExecuation  out  pipeline_result_execuation_t  registered result to the memory stage
- resultOfInstructionAfterExecuation  out  stage_register_data_t  forwarding info of the instruction now in the output register

Behaviour:
- Reset (synchronous): output bubbled=1, MD FSM=IDLE, HI=LO=0, counter=0. `resultOfInstructionAfterExecuation` reports registerId=ZERO, dataReady=1, data=0.
- Input accepted: an instruction is accepted when it is not bubbled, flush=0 and stallRequest=0. It is registered to the output at the next posedge with bubbled=0.
- Otherwise: output bubbled=1 at the next posedge. Payload fields are don't-care, and no HI/LO or MD state change occurs.
- stallRequest sources (OR of):
  - either ForwardingUnit stall, e.g. a load-use dependency whose data is not ready;
  - `signals.mdOp` is not MD_NONE while FSM=BUSY (mdOp set: MD_NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO).
  - stallRequest is combinational and is 0 when the input is bubbled or flush=1.
- Forwarding priority: memory result first, then writeback, then the original regData. Forwarded data also replaces regData in the output record.
- ALU/address:
  - dmAddress = data1 + sign-extended immediate, modulo 2^32.
  - regDataWriteReady=1 when regDataWriteFrom is the ALU or PC+8. It is 0 for DM reads.
  - If regWriteEnabled=0: regDataWriteReady=1 and regDataWrite=0.
- MD FSM, IDLE:
  - An accepted MULT/MULTU/DIV/DIVU latches the operands, loads counter=N and moves to BUSY.
  - The instruction itself retires normally: it has no GPR write and the output is not bubbled.
- MD FSM, BUSY:
  - Performs one iteration per cycle and decrements the counter.
  - When counter=1, HI/LO are written at that posedge and the FSM returns to IDLE. The next MD instruction is accepted in the following cycle.
- MFHI/MFLO: read HI/LO in IDLE only. Data is ready in the same cycle (regDataWriteReady=1).
- MTHI/MTLO: write HI/LO at the accepting posedge.
- Signed ops: operate on magnitudes and fix the signs on completion.
  - MULT/MULTU: {HI,LO} = 64-bit product.
  - DIV/DIVU: LO = quotient, HI = remainder. The remainder takes the sign of the dividend.
- Divide by zero: LO=32'hFFFFFFFF, HI=dividend. Takes full latency.
- DIV of 32'h80000000 by -1: LO=32'h80000000, HI=0.
- flush does not abort an MD operation already in BUSY, because that instruction is older and committed. Only reset aborts it.
- Simultaneous events: flush together with a hazard stall means flush wins, so stallRequest=0 and the output is bubbled.

Optional Feature:
- EXECUATION_FAST_MUL_EN defined:
  - MULT/MULTU compute the 64-bit product combinationally and write HI/LO at the accepting posedge; the FSM stays IDLE.
  - DIV/DIVU remain iterative.
- EXECUATION_FAST_MUL_EN undefined: all MD ops are iterative with latency N.

Test Plan:
- MD_BITS_PER_CYCLE=1: MULT 32'hFFFFFFFE x 3 followed immediately by MFLO -> stallRequest high for 32 cycles, then MFLO result 32'hFFFFFFFA and HI=32'hFFFFFFFF. MFLO reaches the output in the cycle after the FSM returns to IDLE.
- DIV -7 / 2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. DIVU 7 / 0 -> LO=32'hFFFFFFFF, HI=7.
- LW r2 then ADD r3,r2,r2 back-to-back -> one cycle of stallRequest plus an output bubble, then ADD uses the forwarded memory-stage data.
- MULT accepted, flush asserted for the next two instructions -> those outputs bubbled, MULT still completes, HI/LO correct after N cycles.
- Reset asserted while BUSY -> next cycle FSM=IDLE, HI=LO=0, output bubbled=1, stallRequest=0.
- With EXECUATION_FAST_MUL_EN: MULTU 32'hFFFFFFFF x 32'hFFFFFFFF then MFHI -> no stall; HI=32'hFFFFFFFE, LO=1.

Source files
------------

// File: rtl/execuation_stage_md.sv
// -----------------------------------------------------------------------------
// execuation_stage_md
//
// Pipeline execute stage. It resolves operand hazards through two
// forwarding_unit instances and computes the single-cycle ALU result and the
// data-memory address. It also owns the HI/LO registers and an iterative
// multiply/divide (MD) unit. The MD unit runs in the background and stalls
// decode only when another MD instruction arrives while it is busy.
//
// Build option:
//   EXECUATION_FAST_MUL_EN - MULT/MULTU use a combinational 64-bit product and
//                            write HI/LO when accepted. DIV/DIVU stay iterative.
//
// Parameter:
//   MD_BITS_PER_CYCLE - product/quotient bits resolved per MD iteration
//                       (1, 2 or 4); MD latency = 32 / MD_BITS_PER_CYCLE.
//
// Ports:
//   clock, reset                        clock, synchronous active-high reset
//   pipelineResultDecode [139:0]        decode record (MSB first):
//     [139] bubbled      [138:107] pc         [106:103] mdOp    [102:99] aluOp
//     [98] aluSrcImm     [97] regWriteEnabled [96:95] regDataWriteFrom
//     [94:90] regWriteId [89:85] regReadId1   [84:80] regReadId2
//     [79:48] regData1   [47:16] regData2     [15:0] immediate
//   resultOfInstructionAfterMemory    [37:0]  forwarding source, memory stage
//   resultOfInstructionAfterWriteback [37:0]  forwarding source, writeback stage
//     stage register record: [37:33] registerId [32] dataReady [31:0] data
//   flush                               kill the instruction presented by decode
//   stallRequest                        decode must hold its output this cycle
//   pipelineResultExecuation [169:0]    registered record to the memory stage:
//     [169] bubbled      [168:137] pc         [136] regWriteEnabled
//     [135:134] regDataWriteFrom              [133:129] regWriteId
//     [128] regDataWriteReady                 [127:96] regDataWrite
//     [95:64] dmAddress  [63:32] regData1     [31:0] regData2
//   resultOfInstructionAfterExecuation [37:0] forwarding info of the output
//     register (registerId=0, dataReady=1, data=0 when there is no GPR write)
//
// Encodings:
//   mdOp : 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO
//   aluOp: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL,
//          10 SRA, 11 LUI. Shifts move data1 by operand-B[4:0].
//   regDataWriteFrom: 0 ALU, 1 DM read, 2 PC+8
// -----------------------------------------------------------------------------
module execuation_stage_md #(
  parameter int MD_BITS_PER_CYCLE = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [139:0] pipelineResultDecode,
  input  logic [37:0]  resultOfInstructionAfterMemory,
  input  logic [37:0]  resultOfInstructionAfterWriteback,
  input  logic         flush,
  output logic         stallRequest,
  output logic [169:0] pipelineResultExecuation,
  output logic [37:0]  resultOfInstructionAfterExecuation
);

  localparam logic [3:0] MD_NONE = 4'd0, MD_MULT = 4'd1, MD_MULTU = 4'd2,
                         MD_DIV  = 4'd3, MD_DIVU = 4'd4, MD_MFHI  = 4'd5,
                         MD_MFLO = 4'd6, MD_MTHI = 4'd7, MD_MTLO  = 4'd8;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2,
                         ALU_OR  = 4'd3, ALU_XOR = 4'd4, ALU_NOR = 4'd5,
                         ALU_SLT = 4'd6, ALU_SLTU = 4'd7, ALU_SLL = 4'd8,
                         ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11;
  localparam logic [1:0] WF_ALU = 2'd0, WF_DM = 2'd1, WF_PC8 = 2'd2;
  localparam logic [5:0] MD_LATENCY = 6'(32 / MD_BITS_PER_CYCLE);

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

  // One shift-add multiply step on {product_hi, multiplier/product_lo}.
  function automatic logic [63:0] mul_step(input logic [63:0] acc, input logic [31:0] mcand);
    logic [32:0] sum;
    sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
    return {sum, acc[31:1]};
  endfunction

  // One restoring-divide step on {remainder, dividend/quotient}.
  function automatic logic [63:0] div_step(input logic [63:0] acc, input logic [31:0] divisor);
    logic [32:0] r;
    logic [31:0] q;
    r = {acc[63:32], acc[31]};
    q = {acc[30:0], 1'b0};
    if (r >= {1'b0, divisor}) begin
      r    = r - {1'b0, divisor};
      q[0] = 1'b1;
    end
    return {r[31:0], q};
  endfunction

  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? -v : v;
  endfunction

  // Decode record fields
  logic        bubbled_in, alu_src_imm, reg_write_en;
  logic [31:0] pc_in, reg_data1, reg_data2;
  logic [3:0]  md_op, alu_op;
  logic [1:0]  write_from;
  logic [4:0]  write_id, read_id1, read_id2;
  logic [15:0] immediate;

  assign bubbled_in   = pipelineResultDecode[139];
  assign pc_in        = pipelineResultDecode[138:107];
  assign md_op        = pipelineResultDecode[106:103];
  assign alu_op       = pipelineResultDecode[102:99];
  assign alu_src_imm  = pipelineResultDecode[98];
  assign reg_write_en = pipelineResultDecode[97];
  assign write_from   = pipelineResultDecode[96:95];
  assign write_id     = pipelineResultDecode[94:90];
  assign read_id1     = pipelineResultDecode[89:85];
  assign read_id2     = pipelineResultDecode[84:80];
  assign reg_data1    = pipelineResultDecode[79:48];
  assign reg_data2    = pipelineResultDecode[47:16];
  assign immediate    = pipelineResultDecode[15:0];

  logic [31:0] data1, data2;
  logic        fwd_stall1, fwd_stall2;

  forwarding_unit fwd1 (
    .read_id  (read_id1),
    .reg_data (reg_data1),
    .mem_src  (resultOfInstructionAfterMemory),
    .wb_src   (resultOfInstructionAfterWriteback),
    .data     (data1),
    .stall    (fwd_stall1)
  );

  forwarding_unit fwd2 (
    .read_id  (read_id2),
    .reg_data (reg_data2),
    .mem_src  (resultOfInstructionAfterMemory),
    .wb_src   (resultOfInstructionAfterWriteback),
    .data     (data2),
    .stall    (fwd_stall2)
  );

  md_state_t   state, state_next;
  logic [5:0]  counter;
  logic        start_md, done_md, accept, iter_op;
  logic [31:0] hi, lo;

  // An MD instruction must wait while an older one is still iterating.
  assign stallRequest = !bubbled_in && !flush &&
                        (fwd_stall1 || fwd_stall2 || (state == MD_BUSY && md_op != MD_NONE));
  assign accept = !bubbled_in && !flush && !stallRequest;

`ifdef EXECUATION_FAST_MUL_EN
  assign iter_op = (md_op == MD_DIV) || (md_op == MD_DIVU);
  logic signed [63:0] fast_a, fast_b, fast_prod;
  always_comb begin
    fast_a    = (md_op == MD_MULT) ? {{32{data1[31]}}, data1} : {32'd0, data1};
    fast_b    = (md_op == MD_MULT) ? {{32{data2[31]}}, data2} : {32'd0, data2};
    fast_prod = fast_a * fast_b;
  end
`else
  assign iter_op = (md_op == MD_MULT) || (md_op == MD_MULTU) ||
                   (md_op == MD_DIV)  || (md_op == MD_DIVU);
`endif

  // ALU and address
  logic [31:0]        sext_imm, op_b, alu_result, dm_address;
  logic signed [31:0] s_a, s_b;

  assign sext_imm   = {{16{immediate[15]}}, immediate};
  assign op_b       = alu_src_imm ? sext_imm : data2;
  assign s_a        = data1;
  assign s_b        = op_b;
  assign dm_address = data1 + sext_imm;

  always_comb begin
    alu_result = 32'd0;
    case (alu_op)
      ALU_ADD:  alu_result = data1 + op_b;
      ALU_SUB:  alu_result = data1 - op_b;
      ALU_AND:  alu_result = data1 & op_b;
      ALU_OR:   alu_result = data1 | op_b;
      ALU_XOR:  alu_result = data1 ^ op_b;
      ALU_NOR:  alu_result = ~(data1 | op_b);
      ALU_SLT:  alu_result = {31'd0, s_a < s_b};
      ALU_SLTU: alu_result = {31'd0, data1 < op_b};
      ALU_SLL:  alu_result = data1 << op_b[4:0];
      ALU_SRL:  alu_result = data1 >> op_b[4:0];
      ALU_SRA:  alu_result = s_a >>> op_b[4:0];
      ALU_LUI:  alu_result = {immediate, 16'd0};
      default:  alu_result = 32'd0;
    endcase
  end

  logic        write_ready;
  logic [31:0] write_data;

  // MFHI/MFLO reach here only in IDLE, so HI/LO are already final.
  always_comb begin
    write_ready = 1'b1;
    write_data  = 32'd0;
    if (reg_write_en) begin
      case (write_from)
        WF_DM:   write_ready = 1'b0;
        WF_PC8:  write_data  = pc_in + 32'd8;
        default: write_data  = (md_op == MD_MFHI) ? hi :
                               (md_op == MD_MFLO) ? lo : alu_result;
      endcase
    end
  end

  // MD control FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= MD_IDLE;
      counter <= 6'd0;
    end else begin
      state <= state_next;
      if (start_md)
        counter <= MD_LATENCY;
      else if (state == MD_BUSY)
        counter <= counter - 6'd1;
    end
  end

  always_comb begin
    state_next = state;
    start_md   = 1'b0;
    done_md    = 1'b0;
    case (state)
      MD_IDLE: begin
        if (accept && iter_op) begin
          state_next = MD_BUSY;
          start_md   = 1'b1;
        end
      end
      MD_BUSY: begin
        if (counter == 6'd1) begin
          state_next = MD_IDLE;
          done_md    = 1'b1;
        end
      end
      default: state_next = MD_IDLE;
    endcase
  end

  // MD datapath: iterates on magnitudes, signs are applied on completion
  logic        is_div_p, neg_lo_p, neg_hi_p, div_zero_p;
  logic [31:0] acc_hi_p, acc_lo_p, operand_p, dividend_p;
  logic [63:0] acc_step, prod_fix;
  logic [31:0] mag_a, mag_b, div_q, div_r;
  logic        op_signed, op_div;

  assign op_signed = (md_op == MD_MULT) || (md_op == MD_DIV);
  assign op_div    = (md_op == MD_DIV)  || (md_op == MD_DIVU);
  assign mag_a     = magnitude(data1, op_signed);
  assign mag_b     = magnitude(data2, op_signed);

  always_comb begin
    acc_step = {acc_hi_p, acc_lo_p};
    for (int i = 0; i < MD_BITS_PER_CYCLE; i++)
      acc_step = is_div_p ? div_step(acc_step, operand_p) : mul_step(acc_step, operand_p);
  end

  assign prod_fix = neg_lo_p ? -acc_step : acc_step;
  assign div_q    = neg_lo_p ? -acc_step[31:0]  : acc_step[31:0];
  assign div_r    = neg_hi_p ? -acc_step[63:32] : acc_step[63:32];

  always_ff @(posedge clock) begin
    if (start_md) begin
      is_div_p   <= op_div;
      acc_hi_p   <= 32'd0;
      acc_lo_p   <= op_div ? mag_a : mag_b;
      operand_p  <= op_div ? mag_b : mag_a;
      neg_lo_p   <= op_signed && (data1[31] ^ data2[31]);
      neg_hi_p   <= op_signed && data1[31];
      div_zero_p <= (data2 == 32'd0);
      dividend_p <= data1;
    end else if (state == MD_BUSY) begin
      acc_hi_p <= acc_step[63:32];
      acc_lo_p <= acc_step[31:0];
    end
  end

  // HI/LO: an MD completion never coincides with an accepted MD op
  always_ff @(posedge clock) begin
    if (reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (done_md) begin
      if (!is_div_p) begin
        hi <= prod_fix[63:32];
        lo <= prod_fix[31:0];
      end else if (div_zero_p) begin
        hi <= dividend_p;
        lo <= 32'hFFFF_FFFF;
      end else begin
        hi <= div_r;
        lo <= div_q;
      end
    end else if (accept) begin
      case (md_op)
        MD_MTHI: hi <= data1;
        MD_MTLO: lo <= data1;
`ifdef EXECUATION_FAST_MUL_EN
        MD_MULT, MD_MULTU: begin
          hi <= fast_prod[63:32];
          lo <= fast_prod[31:0];
        end
`endif
        default: ;
      endcase
    end
  end

  // ---- stage boundary: execute -> memory output register ----
  logic        vld_p1, rwe_p1, ready_p1;
  logic [1:0]  from_p1;
  logic [4:0]  wid_p1;
  logic [31:0] pc_p1, wdata_p1, dma_p1, d1_p1, d2_p1;

  always_ff @(posedge clock) begin
    if (reset)
      vld_p1 <= 1'b0;
    else
      vld_p1 <= accept;
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      pc_p1    <= pc_in;
      rwe_p1   <= reg_write_en;
      from_p1  <= write_from;
      wid_p1   <= write_id;
      ready_p1 <= write_ready;
      wdata_p1 <= write_data;
      dma_p1   <= dm_address;
      d1_p1    <= data1;
      d2_p1    <= data2;
    end
  end

  assign pipelineResultExecuation = {~vld_p1, pc_p1, rwe_p1, from_p1, wid_p1,
                                     ready_p1, wdata_p1, dma_p1, d1_p1, d2_p1};

  assign resultOfInstructionAfterExecuation = (vld_p1 && rwe_p1) ?
                                              {wid_p1, ready_p1, wdata_p1} :
                                              {5'd0, 1'b1, 32'd0};

endmodule

// -----------------------------------------------------------------------------
// forwarding_unit
//
// Picks the freshest value of one source register. The memory-stage result
// wins over the writeback-stage result, which wins over the register file
// value. A match whose data is not ready yet raises stall. Register 0 is
// never forwarded.
//
// Ports:
//   read_id [4:0]    source register number
//   reg_data [31:0]  register file value
//   mem_src, wb_src  stage records {registerId[4:0], dataReady, data[31:0]}
//   data [31:0]      selected operand
//   stall            matched producer has no data yet
// -----------------------------------------------------------------------------
module forwarding_unit (
  input  logic [4:0]  read_id,
  input  logic [31:0] reg_data,
  input  logic [37:0] mem_src,
  input  logic [37:0] wb_src,
  output logic [31:0] data,
  output logic        stall
);

  always_comb begin
    data  = reg_data;
    stall = 1'b0;
    if (read_id != 5'd0) begin
      if (mem_src[37:33] == read_id) begin
        if (mem_src[32]) data = mem_src[31:0];
        else             stall = 1'b1;
      end else if (wb_src[37:33] == read_id) begin
        if (wb_src[32]) data = wb_src[31:0];
        else            stall = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_execuation_stage_md.sv
// -----------------------------------------------------------------------------
// tb_execuation_stage_md
//
// Directed self-checking bench for execuation_stage_md (MD_BITS_PER_CYCLE=1).
// Inputs change 1 time unit after the falling clock edge. Registered outputs
// are sampled there as well, away from the rising edge.
// -----------------------------------------------------------------------------
module tb_execuation_stage_md;

  localparam logic [3:0] MD_NONE = 4'd0, MD_MULT = 4'd1, MD_MULTU = 4'd2,
                         MD_DIV  = 4'd3, MD_DIVU = 4'd4, MD_MFHI  = 4'd5,
                         MD_MFLO = 4'd6, MD_MTHI = 4'd7, MD_MTLO  = 4'd8;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SLT = 4'd6, ALU_SLTU = 4'd7;
  localparam logic [1:0] WF_ALU = 2'd0, WF_DM = 2'd1, WF_PC8 = 2'd2;
  localparam logic [139:0] BUBBLE = {1'b1, 139'd0};
  localparam logic [37:0]  NO_SRC = {5'd0, 1'b1, 32'd0};
`ifdef EXECUATION_FAST_MUL_EN
  localparam int MUL_LAT   = 0;
  localparam int FLUSH_LAT = 0;
`else
  localparam int MUL_LAT   = 32;
  localparam int FLUSH_LAT = 30;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic [139:0] dec;
  logic [37:0]  mem_src, wb_src, fwd_out;
  logic         flush, stall;
  logic [169:0] res;
  int           n_checks = 0;
  int           n_fail   = 0;

  always #5 clock = ~clock;

  execuation_stage_md #(.MD_BITS_PER_CYCLE(1)) dut (
    .clock                              (clock),
    .reset                              (reset),
    .pipelineResultDecode               (dec),
    .resultOfInstructionAfterMemory     (mem_src),
    .resultOfInstructionAfterWriteback  (wb_src),
    .flush                              (flush),
    .stallRequest                       (stall),
    .pipelineResultExecuation           (res),
    .resultOfInstructionAfterExecuation (fwd_out)
  );

  function automatic logic [139:0] mk(input logic [3:0] md, input logic [3:0] alu,
                                      input logic imm_sel, input logic rwe,
                                      input logic [1:0] from, input logic [4:0] wid,
                                      input logic [4:0] rid1, input logic [4:0] rid2,
                                      input logic [31:0] d1, input logic [31:0] d2,
                                      input logic [15:0] imm, input logic [31:0] pc);
    return {1'b0, pc, md, alu, imm_sel, rwe, from, wid, rid1, rid2, d1, d2, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // Counts stalled cycles (bounded) until the MD unit lets decode through.
  task automatic wait_md(input string tag, input int exp_cycles);
    int n = 0;
    #1;
    while (stall === 1'b1 && n < 40) begin
      @(negedge clock);
      #1;
      n++;
    end
    check(tag, 32'(n), 32'(exp_cycles));
  endtask

  task automatic md_case(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int lat,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    dec = mk(op, ALU_ADD, 1'b0, 1'b0, WF_ALU, 5'd0, 5'd1, 5'd2, a, b, 16'd0, 32'd0);
    step();
    check({tag, "_issue_bubbled"}, 32'(res[169]), 32'd0);
    dec = mk(MD_MFLO, ALU_ADD, 1'b0, 1'b1, WF_ALU, 5'd8, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0, 32'd0);
    wait_md({tag, "_stall_cycles"}, lat);
    step();
    check({tag, "_lo"}, res[127:96], exp_lo);
    dec = mk(MD_MFHI, ALU_ADD, 1'b0, 1'b1, WF_ALU, 5'd9, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0, 32'd0);
    step();
    check({tag, "_hi"}, res[127:96], exp_hi);
  endtask

  initial begin
    reset   = 1'b1;
    flush   = 1'b0;
    mem_src = NO_SRC;
    wb_src  = NO_SRC;
    dec     = BUBBLE;
    step();
    step();
    check("rst_bubbled", 32'(res[169]), 32'd1);
    check("rst_fwd_id", 32'(fwd_out[37:33]), 32'd0);
    check("rst_fwd_ready", 32'(fwd_out[32]), 32'd1);
    check("rst_fwd_data", fwd_out[31:0], 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    reset = 1'b0;

    // ALU add with a negative immediate feeding the address
    dec = mk(MD_NONE, ALU_ADD, 1'b0, 1'b1, WF_ALU, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 16'hFFFC, 32'd0);
    #1 check("add_stall", 32'(stall), 32'd0);
    step();
    check("add_bubbled", 32'(res[169]), 32'd0);
    check("add_data", res[127:96], 32'd12);
    check("add_dmaddr", res[95:64], 32'd1);
    check("add_fwd_id", 32'(fwd_out[37:33]), 32'd3);
    check("add_fwd_data", fwd_out[31:0], 32'd12);

    dec = mk(MD_NONE, ALU_ADD, 1'b1, 1'b1, WF_ALU, 5'd4, 5'd1, 5'd0, 32'h10, 32'd0, 16'h8000, 32'd0);
    step();
    check("addi_data", res[127:96], 32'hFFFF_8010);

    dec = mk(MD_NONE, ALU_SLT, 1'b0, 1'b1, WF_ALU, 5'd4, 5'd1, 5'd2, 32'hFFFF_FFFF, 32'd1, 16'd0, 32'd0);
    step();
    check("slt_data", res[127:96], 32'd1);
    dec = mk(MD_NONE, ALU_SLTU, 1'b0, 1'b1, WF_ALU, 5'd4, 5'd1, 5'd2, 32'hFFFF_FFFF, 32'd1, 16'd0, 32'd0);
    step();
    check("sltu_data", res[127:96], 32'd0);

    dec = mk(MD_NONE, ALU_ADD, 1'b0, 1'b0, WF_ALU, 5'd5, 5'd1, 5'd2, 32'd5, 32'd7, 16'd0, 32'd0);
    step();
    check("nowrite_data", res[127:96], 32'd0);
    check("nowrite_ready", 32'(res[128]), 32'd1);
    check("nowrite_fwd_id", 32'(fwd_out[37:33]), 32'd0);

    dec = mk(MD_NONE, ALU_ADD, 1'b0, 1'b1, WF_PC8, 5'd31, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0, 32'h100);
    step();
    check("pc8_data", res[127:96], 32'h108);

    // Forwarding: each operand from a different stage, then priority
    mem_src = {5'd9, 1'b1, 32'h99};
    wb_src  = {5'd4, 1'b1, 32'h44};
    dec = mk(MD_NONE, ALU_ADD, 1'b0, 1'b1, WF_ALU, 5'd3, 5'd4, 5'd9, 32'd1, 32'd2, 16'd0, 32'd0);
    step();
    check("fwd_mix_data", res[127:96], 32'hDD);
    check("fwd_mix_rd1", res[63:32], 32'h44);
    check("fwd_mix_rd2", res[31:0], 32'h99);
    mem_src = {5'd4, 1'b1, 32'hAAAA};
    wb_src  = {5'd4, 1'b1, 32'hBBBB};
    dec = mk(MD_NONE, ALU_ADD, 1'b0, 1'b1, WF_ALU, 5'd3, 5'd4, 5'd4, 32'd1, 32'd2, 16'd0, 32'd0);
    step();
    check("fwd_prio_data", res[127:96], 32'h15554);
    check("fwd_prio_rd1", res[63:32], 32'hAAAA);
    mem_src = NO_SRC;
    wb_src  = NO_SRC;

    // Load-use: LW r2 then ADD r3,r2,r2
    dec = mk(MD_NONE, ALU_ADD, 1'b0, 1'b1, WF_DM, 5'd2, 5'd1, 5'd0, 32'h1000, 32'd0, 16'h4, 32'd0);
    step();
    check("lw_ready", 32'(res[128]), 32'd0);
    check("lw_dmaddr", res[95:64], 32'h1004);
    check("lw_fwd_ready", 32'(fwd_out[32]), 32'd0);
    mem_src = {5'd2, 1'b0, 32'd0};
    dec = mk(MD_NONE, ALU_ADD, 1'b0, 1'b1, WF_ALU, 5'd3, 5'd2, 5'd2, 32'd0, 32'd0, 16'd0, 32'd0);
    #1 check("lu_stall", 32'(stall), 32'd1);
    step();
    check("lu_bubble", 32'(res[169]), 32'd1);
    mem_src = {5'd2, 1'b1, 32'h55};
    #1 check("lu_release", 32'(stall), 32'd0);
    step();
    check("lu_add_data", res[127:96], 32'hAA);

    // flush beats a hazard stall
    mem_src = {5'd2, 1'b0, 32'd0};
    flush = 1'b1;
    #1 check("flush_stall", 32'(stall), 32'd0);
    step();
    check("flush_bubble", 32'(res[169]), 32'd1);
    flush   = 1'b0;
    mem_src = NO_SRC;

    // Multiply/divide
    md_case("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, MUL_LAT, 32'hFFFF_FFFA, 32'hFFFF_FFFF);
    md_case("mult_neg", MD_MULT, 32'd7, 32'hFFFF_FFF7, MUL_LAT, 32'hFFFF_FFC1, 32'hFFFF_FFFF);
    md_case("multu", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'd1, 32'hFFFF_FFFE);
    md_case("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    md_case("div_negb", MD_DIV, 32'd7, 32'hFFFF_FFFE, 32, 32'hFFFF_FFFD, 32'd1);
    md_case("divu", MD_DIVU, 32'd100, 32'd7, 32, 32'd14, 32'd2);
    md_case("divu_zero", MD_DIVU, 32'd7, 32'd0, 32, 32'hFFFF_FFFF, 32'd7);
    md_case("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32, 32'h8000_0000, 32'd0);

    // MTHI/MTLO then read back
    dec = mk(MD_MTHI, ALU_ADD, 1'b0, 1'b0, WF_ALU, 5'd0, 5'd1, 5'd0, 32'h1234, 32'd0, 16'd0, 32'd0);
    step();
    dec = mk(MD_MTLO, ALU_ADD, 1'b0, 1'b0, WF_ALU, 5'd0, 5'd1, 5'd0, 32'h5678, 32'd0, 16'd0, 32'd0);
    step();
    dec = mk(MD_MFHI, ALU_ADD, 1'b0, 1'b1, WF_ALU, 5'd9, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0, 32'd0);
    step();
    check("mthi", res[127:96], 32'h1234);
    dec = mk(MD_MFLO, ALU_ADD, 1'b0, 1'b1, WF_ALU, 5'd8, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0, 32'd0);
    step();
    check("mtlo", res[127:96], 32'h5678);

    // Flushes behind a running MULTU do not disturb it
    dec = mk(MD_MULTU, ALU_ADD, 1'b0, 1'b0, WF_ALU, 5'd0, 5'd1, 5'd2, 32'h10000, 32'h10000, 16'd0, 32'd0);
    step();
    flush = 1'b1;
    dec = mk(MD_MFLO, ALU_ADD, 1'b0, 1'b1, WF_ALU, 5'd8, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0, 32'd0);
    #1 check("flushmd_stall", 32'(stall), 32'd0);
    step();
    check("flushmd_bub1", 32'(res[169]), 32'd1);
    dec = mk(MD_NONE, ALU_ADD, 1'b0, 1'b1, WF_ALU, 5'd3, 5'd0, 5'd0, 32'd1, 32'd1, 16'd0, 32'd0);
    step();
    check("flushmd_bub2", 32'(res[169]), 32'd1);
    flush = 1'b0;
    dec = mk(MD_MFLO, ALU_ADD, 1'b0, 1'b1, WF_ALU, 5'd8, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0, 32'd0);
    wait_md("flushmd_cycles", FLUSH_LAT);
    step();
    check("flushmd_lo", res[127:96], 32'd0);
    dec = mk(MD_MFHI, ALU_ADD, 1'b0, 1'b1, WF_ALU, 5'd9, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0, 32'd0);
    step();
    check("flushmd_hi", res[127:96], 32'd1);

    // Reset while the divider is busy
    dec = mk(MD_DIVU, ALU_ADD, 1'b0, 1'b0, WF_ALU, 5'd0, 5'd1, 5'd2, 32'd100, 32'd3, 16'd0, 32'd0);
    step();
    dec = mk(MD_MFLO, ALU_ADD, 1'b0, 1'b1, WF_ALU, 5'd8, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0, 32'd0);
    #1 check("rstbusy_pre_stall", 32'(stall), 32'd1);
    reset = 1'b1;
    step();
    check("rstbusy_bubble", 32'(res[169]), 32'd1);
    check("rstbusy_stall", 32'(stall), 32'd0);
    reset = 1'b0;
    step();
    check("rstbusy_lo", res[127:96], 32'd0);
    dec = mk(MD_MFHI, ALU_ADD, 1'b0, 1'b1, WF_ALU, 5'd9, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0, 32'd0);
    step();
    check("rstbusy_hi", res[127:96], 32'd0);
    dec = BUBBLE;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
